// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding,
// register window addresses and STATUS field positions.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_RAW     = 2'd3;

    localparam int STAT_STATE_HI = 31;
    localparam int STAT_STATE_LO = 30;
    localparam int STAT_IN_SVC   = 29;

endpackage

// File: rtl/irq_ctrl_if.sv
// Register bus plus CPU request/acknowledge handshake of the interrupt controller.
interface irq_ctrl_if #(
    parameter int VEC_W = 5
);
    logic             we_i;
    logic [1:0]       addr_i;
    logic [31:0]      wdata_i;
    logic [31:0]      rdata_o;
    logic             Ireq;
    logic             Iack;
    logic [VEC_W-1:0] vec_o;

    modport master (
        output we_i, addr_i, wdata_i, Iack,
        input  rdata_o, Ireq, vec_o
    );

    modport slave (
        input  we_i, addr_i, wdata_i, Iack,
        output rdata_o, Ireq, vec_o
    );
endinterface

// File: rtl/irq_sync_edge.sv
// One interrupt channel: multi-flop synchroniser followed by a rising-edge detector.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], src};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-channel interrupt controller: pending/mask registers, fixed priority
// (index 0 highest) and a registered Ireq/Iack handshake with latched vector.
//
// state   | meaning
// IDLE    | no request outstanding; arbitrates eligible channels
// REQ     | Ireq high, vec_o frozen, waiting for Iack
// SERVICE | CPU handling vec_o; waits for EOI write to STATUS
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int                 NUM_IRQ     = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = {NUM_IRQ{1'b1}},
    parameter int                 SYNC_STAGES = 2,
    parameter int                 VEC_W       = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    irq_ctrl_if.slave          bus
);

    logic [NUM_IRQ-1:0] synced;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] w1c_clr;
    logic [NUM_IRQ-1:0] ack_clr;
    logic               wr_pending;
    logic               wr_mask;
    logic               eoi;
    logic               ack_take;
    state_t             state;
    logic               ireq_q;
    logic               in_service;
    logic [VEC_W-1:0]   vec_q;
    logic [31:0]        rdata;

    for (genvar ch = 0; ch < NUM_IRQ; ch++) begin : g_chan
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst   (rst),
            .src   (irq_i[ch]),
            .level (synced[ch]),
            .rise  (rise[ch])
        );
        assign set_vec[ch] = EDGE_MASK[ch] ? rise[ch] : synced[ch];
    end

    function automatic logic [VEC_W-1:0] prio_enc(input logic [NUM_IRQ-1:0] req);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = VEC_W'(i);
        end
        return idx;
    endfunction

    assign wr_pending = bus.we_i && (bus.addr_i == REG_PENDING);
    assign wr_mask    = bus.we_i && (bus.addr_i == REG_MASK);
    assign eoi        = bus.we_i && (bus.addr_i == REG_STATUS);
    assign ack_take   = (state == REQ) && bus.Iack;
    assign eligible   = pending & mask;

    assign w1c_clr = wr_pending ? bus.wdata_i[NUM_IRQ-1:0] : '0;
    // Level channels keep their pending bit until software clears it.
    assign ack_clr = ack_take ? (({{(NUM_IRQ-1){1'b0}}, 1'b1} << vec_q) & EDGE_MASK) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= (pending & ~w1c_clr & ~ack_clr) | set_vec;
            if (wr_mask) mask <= bus.wdata_i[NUM_IRQ-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ireq_q     <= 1'b0;
            vec_q      <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state  <= REQ;
                        ireq_q <= 1'b1;
                        vec_q  <= prio_enc(eligible);
                    end
                end
                REQ: begin
                    // Held regardless of later clear/mask; only Iack releases it.
                    if (bus.Iack) begin
                        state      <= SERVICE;
                        ireq_q     <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ireq_q     <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.addr_i)
            REG_PENDING: rdata[NUM_IRQ-1:0] = pending;
            REG_MASK:    rdata[NUM_IRQ-1:0] = mask;
            REG_STATUS: begin
                rdata[STAT_STATE_HI:STAT_STATE_LO] = state;
                rdata[STAT_IN_SVC]                 = in_service;
                rdata[VEC_W-1:0]                   = vec_q;
            end
            REG_RAW:     rdata[NUM_IRQ-1:0] = synced;
            default:     rdata = '0;
        endcase
    end

    assign bus.rdata_o = rdata;
    assign bus.Ireq    = ireq_q;
    assign bus.vec_o   = vec_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: 8 channels, channel 1 level-triggered.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic [31:0] d;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    irq_ctrl_if #(.VEC_W(5)) bus ();

    irq_ctrl #(
        .NUM_IRQ     (8),
        .EDGE_MASK   (8'hFD),
        .SYNC_STAGES (2),
        .VEC_W       (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .irq_i (irq),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        bus.addr_i  = a;
        bus.wdata_i = v;
        bus.we_i    = 1'b1;
        tick();
        bus.we_i    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.addr_i = a;
        #1;
        v = bus.rdata_o;
    endtask

    task automatic ack();
        bus.Iack = 1'b1;
        tick();
        bus.Iack = 1'b0;
    endtask

    task automatic wait_ireq(input int max, input string tag);
        int k = 0;
        while (!bus.Ireq && k < max) begin
            tick();
            k++;
        end
        chk(tag, 32'(bus.Ireq), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        irq = '0;
        bus.we_i = 1'b0;
        bus.addr_i = 2'd0;
        bus.wdata_i = '0;
        bus.Iack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_ireq", 32'(bus.Ireq), 32'd0);
        chk("rst_vec", 32'(bus.vec_o), 32'd0);
        rd(2'd0, d); chk("rst_pending", d, 32'h0);
        rd(2'd1, d); chk("rst_mask", d, 32'h0);
        rd(2'd2, d); chk("rst_status", d, 32'h0);

        // Single edge channel 3: latency and acknowledge
        wr(2'd1, 32'h08);
        irq[3] = 1'b1;
        tick();
        irq[3] = 1'b0;
        tick();
        tick();
        chk("t1_ireq_edge3", 32'(bus.Ireq), 32'd0);
        tick();
        chk("t1_ireq_edge4", 32'(bus.Ireq), 32'd1);
        chk("t1_vec", 32'(bus.vec_o), 32'd3);
        ack();
        chk("t1_ireq_after_ack", 32'(bus.Ireq), 32'd0);
        rd(2'd0, d); chk("t1_pending", d, 32'h0);
        rd(2'd2, d); chk("t1_in_service", 32'(d[29]), 32'd1);
        chk("t1_status", d, 32'hA000_0003);
        wr(2'd2, 32'h0);
        rd(2'd2, d); chk("t1_status_eoi", d, 32'h0000_0003);

        // Simultaneous 5 and 2: priority then re-arbitration
        wr(2'd1, 32'hFF);
        irq = 8'h24;
        tick();
        irq = 8'h00;
        wait_ireq(8, "t2_req");
        chk("t2_vec_first", 32'(bus.vec_o), 32'd2);
        ack();
        rd(2'd0, d); chk("t2_pending_after_ack", d, 32'h20);
        wr(2'd2, 32'h0);
        chk("t2_ireq_eoi_edge", 32'(bus.Ireq), 32'd0);
        tick();
        chk("t2_ireq_rearb", 32'(bus.Ireq), 32'd1);
        chk("t2_vec_second", 32'(bus.vec_o), 32'd5);
        ack();
        wr(2'd2, 32'h0);

        // Level channel 1 held high
        irq[1] = 1'b1;
        wait_ireq(8, "t3_req");
        chk("t3_vec", 32'(bus.vec_o), 32'd1);
        rd(2'd3, d); chk("t3_raw", d, 32'h02);
        ack();
        rd(2'd0, d); chk("t3_pending_level", d, 32'h02);
        wr(2'd2, 32'h0);
        tick();
        chk("t3_ireq_reassert", 32'(bus.Ireq), 32'd1);
        chk("t3_vec_again", 32'(bus.vec_o), 32'd1);
        ack();
        irq[1] = 1'b0;
        repeat (4) tick();
        wr(2'd0, 32'h02);
        rd(2'd0, d); chk("t3_pending_w1c", d, 32'h0);
        wr(2'd2, 32'h0);
        tick();
        tick();
        chk("t3_ireq_quiet", 32'(bus.Ireq), 32'd0);

        // Masked channel 0 stays pending until enabled
        wr(2'd1, 32'h0);
        irq[0] = 1'b1;
        tick();
        irq[0] = 1'b0;
        repeat (4) tick();
        rd(2'd0, d); chk("t4_pending_masked", d, 32'h01);
        chk("t4_ireq_masked", 32'(bus.Ireq), 32'd0);
        wr(2'd1, 32'h01);
        chk("t4_ireq_one_cycle", 32'(bus.Ireq), 32'd0);
        tick();
        chk("t4_ireq_two_cycles", 32'(bus.Ireq), 32'd1);
        chk("t4_vec", 32'(bus.vec_o), 32'd0);
        ack();
        wr(2'd2, 32'h0);

        // W1C of bit 4 colliding with a new edge on channel 4
        wr(2'd1, 32'h0);
        irq[4] = 1'b1;
        tick();
        tick();
        wr(2'd0, 32'h10);
        irq[4] = 1'b0;
        rd(2'd0, d); chk("t5_set_wins", d, 32'h10);
        wr(2'd0, 32'h10);
        rd(2'd0, d); chk("t5_plain_w1c", d, 32'h0);

        // Reset while in REQ
        irq[4] = 1'b1;
        tick();
        irq[4] = 1'b0;
        repeat (3) tick();
        wr(2'd1, 32'h10);
        tick();
        chk("t6_ireq_req", 32'(bus.Ireq), 32'd1);
        chk("t6_vec_req", 32'(bus.vec_o), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_ireq_rst", 32'(bus.Ireq), 32'd0);
        chk("t6_vec_rst", 32'(bus.vec_o), 32'd0);
        rd(2'd1, d); chk("t6_mask_rst", d, 32'h0);
        rd(2'd0, d); chk("t6_pending_rst", d, 32'h0);
        rd(2'd2, d); chk("t6_status_rst", d, 32'h0);

        // Iack in IDLE has no effect
        ack();
        rd(2'd2, d); chk("t7_iack_idle", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
